axi_wr_arbiter: RTL and testbench
=================================

# axi_wr_arbiter

Per-slave write-channel arbiter for `axi_interconnect`: shares one downstream slave's AW/W/B channels among `MST_N` upstream masters. It picks one requester round-robin and forwards its address handshake. It then locks the W path to that master until the `wlast` beat, and routes the single B response back before re-arbitrating. The block emits a one-hot grant; the interconnect uses it to steer AW/W payload muxes and B payload fan-out.

## Interface
- `MST_N`, 4, number of requesting masters (≥2)
- `GW`, `$clog2(MST_N)`, grant index width
- `aclk` in 1: clock; all logic rising-edge
- `aresetn` in 1: asynchronous assert, active-low reset
- `s_awvalid` in MST_N: per-master AW valid, already address-decoded for this slave
- `s_awready` out MST_N: per-master AW ready
- `s_awqos` in 4*MST_N: per-master awqos, master i at [4i+3:4i] (used only with QoS macro)
- `s_wvalid`, `s_wlast` in MST_N: per-master W valid / last
- `s_wready` out MST_N: per-master W ready
- `s_bwvalid` out MST_N: per-master B valid
- `s_bwready` in MST_N: per-master B ready
- `m_awvalid` out 1, `m_awready` in 1: downstream AW handshake
- `m_wvalid`, `m_wlast` out 1, `m_wready` in 1: downstream W handshake
- `m_bwvalid` in 1, `m_bwready` out 1: downstream B handshake
- `grant_oh` out MST_N: one-hot current owner, 0 in IDLE
- `grant_idx` out GW: binary index of owner, holds last value in IDLE
- `busy` out 1: high in any state except IDLE

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. One transaction in flight per slave.
- IDLE: if any `s_awvalid`, select winner and register `grant_oh`/`grant_idx`, go ADDR. No requests: stay.
- Round-robin: search starts at pointer `rr`, increasing index with wrap at MST_N-1→0. First asserted request wins.
- ADDR: `m_awvalid = s_awvalid[g]`; `s_awready[g] = m_awready`. On `m_awvalid & m_awready` go DATA.
- DATA: `m_wvalid = s_wvalid[g]`, `m_wlast = s_wlast[g]`, `s_wready[g] = m_wready`. On a handshake with `m_wlast=1` go RESP. Non-last beats stay in DATA.
- RESP: `s_bwvalid[g] = m_bwvalid`, `m_bwready = s_bwready[g]`. On handshake: go IDLE, `rr <= g+1` (mod MST_N), `grant_oh <= 0`.
- Non-granted masters see ready/valid = 0 on every channel. All forwarded ready/valid signals are 0 outside their owning state.
- W beats presented before AW is accepted are stalled (`s_wready` = 0); this is AXI-legal.
- A request that drops in IDLE before the grant registers is ignored. After grant, the AXI stability rule holds `s_awvalid[g]` high.

## Timing
- Reset (`aresetn`=0, asynchronous): state IDLE, `rr`=0, `grant_oh`=0, `grant_idx`=0, `busy`=0. All `s_*ready`, `s_bwvalid`, `m_*valid`, `m_bwready`, `m_wlast` = 0.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives `m_awvalid`=1 after edge N.
- Forwarded valid/ready paths are combinational from registered state/grant plus the live handshake inputs. No combinational path from any `s_awvalid` to the grant.
- Minimum transaction: 1 (arb) + 1 (AW) + L (W beats) + 1 (B) cycles. Back-to-back grants have 1 idle cycle between B handshake and next ADDR.
- Reset mid-burst: FSM returns to IDLE immediately. The partial burst is abandoned and no response is generated; the system resets both sides together.
- Simultaneous requests from all masters: each is served exactly once per MST_N grants.

## Configuration
- `AXI_ARB_QOS_EN` defined: IDLE winner is the requester with the highest `s_awqos`. Ties are broken round-robin from `rr`, and `rr` update is unchanged.
- Undefined: `s_awqos` ignored, pure round-robin.

## Test plan
- Single master 2 requests, 4-beat burst (wlast on beat 4) → `grant_oh`=0b0100, AW forwarded at cycle 1, 4 W beats, B routed only to master 2, `busy` low after B.
- All 4 masters request continuously, 1-beat bursts → grant order 0,1,2,3,0; `rr` wraps 3→0.
- Downstream `m_wready` toggled 1,0,1,0 during 3-beat burst → exactly 3 beats pass, FSM stays in DATA until `wlast` handshake.
- Master 1 drives `s_wvalid` before AW grant → `s_wready[1]`=0 until AW handshake completes.
- Assert `aresetn`=0 in DATA mid-burst → all outputs 0 the same cycle; after release, new request arbitrates from `rr`=0.
- With `AXI_ARB_QOS_EN`: masters 0 and 3 request, qos 2 and 9 → master 3 granted first. Equal qos with `rr`=1 → master 3 before 0.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Write-channel arbiter for one slave: round-robin owner (highest awqos first when AXI_ARB_QOS_EN is defined), 1-cycle arbitration.
// W and B stay locked to the owner until the wlast beat and the B handshake; non-owners see ready/valid held at 0.
module axi_wr_arbiter #(
    parameter int MST_N = 4,
    parameter int GW    = $clog2(MST_N)
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [MST_N-1:0]   s_awvalid,
    output logic [MST_N-1:0]   s_awready,
    input  logic [4*MST_N-1:0] s_awqos,
    input  logic [MST_N-1:0]   s_wvalid,
    input  logic [MST_N-1:0]   s_wlast,
    output logic [MST_N-1:0]   s_wready,
    output logic [MST_N-1:0]   s_bwvalid,
    input  logic [MST_N-1:0]   s_bwready,
    output logic               m_awvalid,
    input  logic               m_awready,
    output logic               m_wvalid,
    output logic               m_wlast,
    input  logic               m_wready,
    input  logic               m_bwvalid,
    output logic               m_bwready,
    output logic [MST_N-1:0]   grant_oh,
    output logic [GW-1:0]      grant_idx,
    output logic               busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    localparam logic [GW:0] N_W = (GW+1)'(MST_N);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GW-1:0]    r_rr;
    logic [GW-1:0]    r_gidx;
    logic [MST_N-1:0] r_goh;
    logic [GW-1:0]    w_ord [MST_N];
    logic [3:0]       w_qos [MST_N];
    logic [GW-1:0]    w_win_idx;
    logic [MST_N-1:0] w_win_oh;
    logic [3:0]       w_best_qos;
    logic             w_any_req;
    logic [GW-1:0]    w_rr_nxt;

    // w_ord[k] is the k-th master visited when searching from r_rr with wrap.
    for (genvar k = 0; k < MST_N; k++) begin : g_ord
        logic [GW:0] w_sum;
        assign w_sum    = {1'b0, r_rr} + (GW+1)'(k);
        assign w_ord[k] = (w_sum >= N_W) ? GW'(w_sum - N_W) : w_sum[GW-1:0];
`ifdef AXI_ARB_QOS_EN
        assign w_qos[k] = s_awqos[4*k +: 4];
`else
        assign w_qos[k] = 4'd0;
`endif
    end

`ifndef AXI_ARB_QOS_EN
    logic w_unused_qos;
    assign w_unused_qos = ^s_awqos;
`endif

    // Strictly-greater qos replaces the candidate, so ties keep the earliest in round-robin order.
    always_comb begin
        w_any_req  = 1'b0;
        w_win_idx  = r_rr;
        w_best_qos = 4'd0;
        for (int k = 0; k < MST_N; k++) begin
            if (s_awvalid[w_ord[k]] && (!w_any_req || (w_qos[w_ord[k]] > w_best_qos))) begin
                w_any_req  = 1'b1;
                w_win_idx  = w_ord[k];
                w_best_qos = w_qos[w_ord[k]];
            end
        end
    end

    assign w_win_oh = {{(MST_N-1){1'b0}}, 1'b1} << w_win_idx;
    assign w_rr_nxt = (r_gidx == GW'(MST_N-1)) ? '0 : r_gidx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        s_awready   = '0;
        s_wready    = '0;
        s_bwvalid   = '0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_wlast     = 1'b0;
        m_bwready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                m_awvalid         = s_awvalid[r_gidx];
                s_awready[r_gidx] = m_awready;
                if (s_awvalid[r_gidx] && m_awready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                m_wvalid         = s_wvalid[r_gidx];
                m_wlast          = s_wlast[r_gidx];
                s_wready[r_gidx] = m_wready;
                if (s_wvalid[r_gidx] && m_wready && s_wlast[r_gidx]) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                s_bwvalid[r_gidx] = m_bwvalid;
                m_bwready         = s_bwready[r_gidx];
                if (m_bwvalid && s_bwready[r_gidx]) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_gidx  <= '0;
            r_goh   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_req) begin
                r_gidx <= w_win_idx;
                r_goh  <= w_win_oh;
            end
            if (r_state == ST_RESP && w_state_nxt == ST_IDLE) begin
                r_goh <= '0;
                r_rr  <= w_rr_nxt;
            end
        end
    end

    assign grant_oh  = r_goh;
    assign grant_idx = r_gidx;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: transaction-level reference model checked every negedge plus directed literal expectations.
`timescale 1ns/1ps
module tb_axi_wr_arbiter;

    localparam int N = 4;
    localparam int PH_IDLE = 0, PH_ADDR = 1, PH_DATA = 2, PH_RESP = 3;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [N-1:0]   s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bwvalid, s_bwready;
    logic [4*N-1:0] s_awqos;
    logic           m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bwvalid, m_bwready;
    logic [N-1:0]   grant_oh;
    logic [1:0]     grant_idx;
    logic           busy;

    int n_chk = 0;
    int n_err = 0;

    axi_wr_arbiter #(.MST_N(N)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awqos(s_awqos),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bwvalid(s_bwvalid), .s_bwready(s_bwready),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_bwvalid(m_bwvalid), .m_bwready(m_bwready),
        .grant_oh(grant_oh), .grant_idx(grant_idx), .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int md_ph = PH_IDLE;
    int md_own = 0;
    int md_rr = 0;
    int md_gidx = 0;

    // Winner = highest qos (when enabled), then smallest round-robin distance from rr.
    function automatic int pick(input logic [N-1:0] req, input int rr);
        int best = -1;
        int bq = -1;
        int bd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                int q;
                int d;
`ifdef AXI_ARB_QOS_EN
                q = int'(s_awqos[4*i +: 4]);
`else
                q = 0;
`endif
                d = (i - rr + N) % N;
                if (q > bq || (q == bq && d < bd)) begin
                    best = i;
                    bq = q;
                    bd = d;
                end
            end
        end
        return best;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            md_ph <= PH_IDLE; md_own <= 0; md_rr <= 0; md_gidx <= 0;
        end else begin
            case (md_ph)
                PH_IDLE: if (|s_awvalid) begin
                    md_own  <= pick(s_awvalid, md_rr);
                    md_gidx <= pick(s_awvalid, md_rr);
                    md_ph   <= PH_ADDR;
                end
                PH_ADDR: if (s_awvalid[md_own] && m_awready) md_ph <= PH_DATA;
                PH_DATA: if (s_wvalid[md_own] && m_wready && s_wlast[md_own]) md_ph <= PH_RESP;
                PH_RESP: if (m_bwvalid && s_bwready[md_own]) begin
                    md_ph <= PH_IDLE;
                    md_rr <= (md_own + 1) % N;
                end
                default: md_ph <= PH_IDLE;
            endcase
        end
    end

    always @(negedge aclk) begin : cmp
        logic [N-1:0] e_awr, e_wr, e_bv;
        logic e_awv, e_wv, e_wl, e_br;
        e_awr = '0; e_wr = '0; e_bv = '0;
        e_awv = 1'b0; e_wv = 1'b0; e_wl = 1'b0; e_br = 1'b0;
        case (md_ph)
            PH_ADDR: begin e_awv = s_awvalid[md_own]; e_awr[md_own] = m_awready; end
            PH_DATA: begin e_wv = s_wvalid[md_own]; e_wl = s_wlast[md_own]; e_wr[md_own] = m_wready; end
            PH_RESP: begin e_bv[md_own] = m_bwvalid; e_br = s_bwready[md_own]; end
            default: ;
        endcase
        chk("grant_oh",  int'(grant_oh),  (md_ph == PH_IDLE) ? 0 : (1 << md_own));
        chk("grant_idx", int'(grant_idx), md_gidx);
        chk("busy",      int'(busy),      (md_ph != PH_IDLE) ? 1 : 0);
        chk("m_awvalid", int'(m_awvalid), int'(e_awv));
        chk("s_awready", int'(s_awready), int'(e_awr));
        chk("m_wvalid",  int'(m_wvalid),  int'(e_wv));
        chk("m_wlast",   int'(m_wlast),   int'(e_wl));
        chk("s_wready",  int'(s_wready),  int'(e_wr));
        chk("s_bwvalid", int'(s_bwvalid), int'(e_bv));
        chk("m_bwready", int'(m_bwready), int'(e_br));
    end

    // ---------------- master / slave stimulus ----------------
    bit aw_pend[N], aw_done[N], wearly[N];
    bit hs_aw[N], hs_w[N], hs_b[N];
    int w_left[N], blen[N], n_burst[N], b_cnt[N];
    int ds_beats, ds_last, busy_cyc;
    logic [N-1:0] goh_seen;
    int g_log[$];
    bit tog = 1'b0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_awvalid[i] = aw_pend[i];
            s_wvalid[i]  = (w_left[i] > 0) && (aw_done[i] || wearly[i]);
            s_wlast[i]   = (w_left[i] == 1);
        end
        s_bwready = '1;
    endtask

    task automatic start(input int m, input int len);
        aw_pend[m] = 1'b1; aw_done[m] = 1'b0; w_left[m] = len; blen[m] = len;
    endtask

    task automatic clear();
        ds_beats = 0; ds_last = 0; busy_cyc = 0; goh_seen = '0;
        g_log.delete();
        for (int i = 0; i < N; i++) begin
            b_cnt[i] = 0; n_burst[i] = 0;
        end
    endtask

    task automatic step();
        @(negedge aclk);
        for (int i = 0; i < N; i++) begin
            hs_aw[i] = s_awvalid[i] & s_awready[i];
            hs_w[i]  = s_wvalid[i] & s_wready[i];
            hs_b[i]  = s_bwvalid[i] & s_bwready[i];
        end
        if (m_wvalid && m_wready) begin
            ds_beats++;
            if (m_wlast) ds_last++;
        end
        if (m_awvalid && m_awready) g_log.push_back(int'(grant_idx));
        goh_seen |= grant_oh;
        if (busy) busy_cyc++;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_aw[i]) begin aw_pend[i] = 1'b0; aw_done[i] = 1'b1; end
            if (hs_w[i] && w_left[i] > 0) w_left[i]--;
            if (hs_b[i]) begin
                b_cnt[i]++;
                aw_done[i] = 1'b0;
                if (n_burst[i] > 0) begin
                    n_burst[i]--;
                    start(i, blen[i]);
                end
            end
        end
        m_wready = tog ? ~m_wready : 1'b1;
        drive();
    endtask

    task automatic run_idle(input string nm, input int budget);
        bit done = 1'b0;
        int c = 0;
        while (!done && c < budget) begin
            step();
            c++;
            done = !busy;
            for (int i = 0; i < N; i++)
                if (aw_pend[i] || w_left[i] != 0 || n_burst[i] != 0) done = 1'b0;
        end
        chk({nm, " idle"}, int'(done), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " grant_oh"},  int'(grant_oh),  0);
        chk({nm, " grant_idx"}, int'(grant_idx), 0);
        chk({nm, " busy"},      int'(busy),      0);
        chk({nm, " s_awready"}, int'(s_awready), 0);
        chk({nm, " s_wready"},  int'(s_wready),  0);
        chk({nm, " s_bwvalid"}, int'(s_bwvalid), 0);
        chk({nm, " m_awvalid"}, int'(m_awvalid), 0);
        chk({nm, " m_wvalid"},  int'(m_wvalid),  0);
        chk({nm, " m_wlast"},   int'(m_wlast),   0);
        chk({nm, " m_bwready"}, int'(m_bwready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord[5];
        int k;
        exp_ord = '{0, 1, 2, 3, 0};
        s_awqos = '0; m_awready = 1'b1; m_wready = 1'b1; m_bwvalid = 1'b1;
        clear();
        drive();
        repeat (3) @(posedge aclk);
        #2;
        chk_all_zero("reset");
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // All four request together, 1-beat bursts; master 0 asks twice.
        clear();
        for (int i = 0; i < N; i++) start(i, 1);
        n_burst[0] = 1;
        drive();
        run_idle("rr", 60);
        chk("rr grants", g_log.size(), 5);
        for (k = 0; k < 5 && k < g_log.size(); k++) chk("rr order", g_log[k], exp_ord[k]);
        chk("rr b0", b_cnt[0], 2);
        chk("rr b3", b_cnt[3], 1);
        chk("rr busy cycles", busy_cyc, 15);

        // Single master 2, 4-beat burst.
        clear();
        start(2, 4);
        drive();
        step();
        #1;
        chk("m2 aw at cycle1", int'(m_awvalid), 1);
        chk("m2 grant_oh", int'(grant_oh), 4);
        chk("m2 s_awready", int'(s_awready), 4);
        run_idle("m2", 30);
        chk("m2 grant seen", int'(goh_seen), 4);
        chk("m2 beats", ds_beats, 4);
        chk("m2 b to 2", b_cnt[2], 1);
        chk("m2 b others", b_cnt[0] + b_cnt[1] + b_cnt[3], 0);
        chk("m2 busy cycles", busy_cyc, 6);
        chk("m2 busy after", int'(busy), 0);

        // Downstream wready toggling during 3-beat burst.
        clear();
        tog = 1'b1;
        start(0, 3);
        drive();
        run_idle("wtog", 40);
        tog = 1'b0;
        m_wready = 1'b1;
        chk("wtog beats", ds_beats, 3);
        chk("wtog last", ds_last, 1);
        chk("wtog b", b_cnt[0], 1);

        // Master 1 presents W before its AW is accepted.
        clear();
        m_awready = 1'b0;
        wearly[1] = 1'b1;
        start(1, 2);
        drive();
        repeat (3) begin
            step();
            #1;
            chk("early s_wready1", int'(s_wready[1]), 0);
            chk("early m_wvalid", int'(m_wvalid), 0);
        end
        m_awready = 1'b1;
        run_idle("early", 30);
        wearly[1] = 1'b0;
        chk("early beats", ds_beats, 2);
        chk("early b", b_cnt[1], 1);

        // Reset in the middle of a burst.
        clear();
        start(2, 4);
        drive();
        k = 0;
        while (ds_beats < 2 && k < 20) begin step(); k++; end
        chk("midrst reached data", ds_beats, 2);
        #1 aresetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        for (int i = 0; i < N; i++) begin
            aw_pend[i] = 1'b0; aw_done[i] = 1'b0; w_left[i] = 0;
        end
        drive();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        clear();
        start(1, 1);
        start(3, 1);
        drive();
        step();
        #1;
        chk("postrst grant_idx", int'(grant_idx), 1);
        chk("postrst grant_oh", int'(grant_oh), 2);
        run_idle("postrst", 30);
        chk("postrst grants", g_log.size(), 2);
        if (g_log.size() == 2) chk("postrst second", g_log[1], 3);

`ifdef AXI_ARB_QOS_EN
        // qos 2 vs 9, then equal qos with rr=1.
        clear();
        s_awqos = 16'h9002;
        start(0, 1);
        start(3, 1);
        drive();
        run_idle("qos", 30);
        s_awqos = 16'h5005;
        start(0, 1);
        start(3, 1);
        drive();
        run_idle("qos tie", 30);
        chk("qos grants", g_log.size(), 4);
        if (g_log.size() == 4) begin
            chk("qos first", g_log[0], 3);
            chk("qos second", g_log[1], 0);
            chk("qos tie first", g_log[2], 3);
            chk("qos tie second", g_log[3], 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
